// File: rtl/mux_sel_sequencer_if.sv
// Word handshake into the mux select sequencer.
// The upstream side drives the word and in_valid; the sequencer answers with in_ready.
interface mux_sel_sequencer_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mux_sel_sequencer.sv
// Upstream controller for the 8:1 bit-select mux: holds a word on data_out and steps
// sel LSB-first, one position per DIV clocks, with frame flags.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// SHIFT | walking sel through 0..N-1, bit_valid high
// DONE  | one-cycle end-of-frame, done high
module mux_sel_sequencer #(
    parameter int SEL_W = 3,
    parameter int DIV   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    mux_sel_sequencer_if.slave      up,
    input  logic                    abort,
    output logic [(2**SEL_W)-1:0]   data_out,
    output logic [SEL_W-1:0]        sel,
    output logic                    bit_valid,
    output logic                    last,
    output logic                    busy,
    output logic                    done
);
    localparam int                N        = 2**SEL_W;
    localparam int                TICK_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(DIV - 1);
    localparam logic [SEL_W-1:0]  SEL_MAX  = SEL_W'(N - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic              tick_end;

    // With DIV==1 TICK_MAX is 0, so tick never leaves 0 and sel moves every clock.
    assign tick_end    = (tick == TICK_MAX);
    assign up.in_ready = (state == IDLE);
    assign last        = (state == SHIFT) && (sel == SEL_MAX) && tick_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data_out  <= '0;
            sel       <= '0;
            tick      <= '0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (up.in_valid) begin
                        data_out  <= up.in_data;
                        sel       <= '0;
                        tick      <= '0;
                        state     <= SHIFT;
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state     <= IDLE;
                        sel       <= '0;
                        tick      <= '0;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (last) begin
                        // sel stays at N-1 through DONE and into IDLE
                        state     <= DONE;
                        tick      <= '0;
                        bit_valid <= 1'b0;
                        done      <= 1'b1;
                    end else if (tick_end) begin
                        tick <= '0;
                        sel  <= sel + SEL_W'(1);
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (abort) begin
                        sel  <= '0;
                        tick <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: a DIV=1 and a DIV=3 instance, per-cycle expected
// observations queued by a reference model and compared as the frames play out.
module tb_mux_sel_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_sel_sequencer_if #(.N(8)) if1 ();
    mux_sel_sequencer_if #(.N(8)) if3 ();

    logic       abort1, abort3;
    logic [7:0] data_out1, data_out3;
    logic [2:0] sel1, sel3;
    logic       bit_valid1, bit_valid3, last1, last3, busy1, busy3, done1, done3;

    mux_sel_sequencer #(.SEL_W(3), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .up(if1), .abort(abort1), .data_out(data_out1), .sel(sel1),
        .bit_valid(bit_valid1), .last(last1), .busy(busy1), .done(done1));

    mux_sel_sequencer #(.SEL_W(3), .DIV(3)) dut3 (
        .clk(clk), .rst(rst), .up(if3), .abort(abort3), .data_out(data_out3), .sel(sel3),
        .bit_valid(bit_valid3), .last(last3), .busy(busy3), .done(done3));

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] sel;
        logic       mbit;
        logic       last;
        logic       bv;
        logic       busy;
        logic       done;
        logic       rdy;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: one entry per cycle from T+1 (first SHIFT) to the first IDLE cycle.
    function automatic void push_frame(input logic [7:0] w, input int div);
        obs_t e;
        for (int i = 0; i < 8 * div; i++) begin
            e.data = w; e.sel = 3'(i / div); e.mbit = w[i / div];
            e.last = (i == 8 * div - 1); e.bv = 1'b1; e.busy = 1'b1; e.done = 1'b0; e.rdy = 1'b0;
            exp_q.push_back(e);
        end
        e.data = w; e.sel = 3'd7; e.mbit = w[7]; e.last = 1'b0;
        e.bv = 1'b0; e.busy = 1'b1; e.done = 1'b1; e.rdy = 1'b0;
        exp_q.push_back(e);
        e.busy = 1'b0; e.done = 1'b0; e.rdy = 1'b1;
        exp_q.push_back(e);
    endfunction

    function automatic obs_t obs1();
        obs_t o;
        o.data = data_out1; o.sel = sel1; o.mbit = data_out1[sel1]; o.last = last1;
        o.bv = bit_valid1; o.busy = busy1; o.done = done1; o.rdy = if1.in_ready;
        return o;
    endfunction

    function automatic obs_t obs3();
        obs_t o;
        o.data = data_out3; o.sel = sel3; o.mbit = data_out3[sel3]; o.last = last3;
        o.bv = bit_valid3; o.busy = busy3; o.done = done3; o.rdy = if3.in_ready;
        return o;
    endfunction

    task automatic test_reset();
        obs_t r, o;
        r = '0; r.rdy = 1'b1;
        #3;
        o = obs1();
        n_cmp++;
        if (o !== r) begin n_err++; $display("FAIL reset_div1 got %h want %h", o, r); end
        o = obs3();
        n_cmp++;
        if (o !== r) begin n_err++; $display("FAIL reset_div3 got %h want %h", o, r); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single_div1();
        obs_t e, o;
        int   cyc = 1;
        @(negedge clk); if1.in_valid = 1'b1; if1.in_data = 8'hA5;
        @(negedge clk); if1.in_valid = 1'b0; if1.in_data = 8'h00;
        push_frame(8'hA5, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs1();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL a5_div1 T+%0d got %h want %h", cyc, o, e); end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_div3();
        obs_t e, o;
        int   cyc = 1;
        @(negedge clk); if3.in_valid = 1'b1; if3.in_data = 8'h81;
        @(negedge clk); if3.in_valid = 1'b0; if3.in_data = 8'h00;
        push_frame(8'h81, 3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs3();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL 81_div3 T+%0d got %h want %h", cyc, o, e); end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        int   cyc = 1;
        @(negedge clk); if1.in_valid = 1'b1; if1.in_data = 8'h0F;
        @(negedge clk); if1.in_data = 8'hF0;
        push_frame(8'h0F, 1);
        push_frame(8'hF0, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs1();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL back_to_back T+%0d got %h want %h", cyc, o, e); end
            if (exp_q.size() == 0) if1.in_valid = 1'b0;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        obs_t e, o;
        int   idx = 0;
        @(negedge clk); if1.in_valid = 1'b1; if1.in_data = 8'hC3;
        @(negedge clk); if1.in_valid = 1'b0;
        push_frame(8'hC3, 1);
        while (exp_q.size() > 5) void'(exp_q.pop_back());
        e = '0; e.data = 8'hC3; e.sel = 3'd0; e.mbit = 1'b1; e.rdy = 1'b1;
        exp_q.push_back(e);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs1();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL abort idx%0d got %h want %h", idx, o, e); end
            if (idx == 4) abort1 = 1'b1;
            if (idx == 5) begin
                // abort still high in IDLE must not block this handshake
                if1.in_valid = 1'b1; if1.in_data = 8'h66;
                push_frame(8'h66, 1);
            end
            if (idx == 6) begin abort1 = 1'b0; if1.in_valid = 1'b0; end
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        obs_t e, o, r;
        int   idx = 0;
        r = '0; r.rdy = 1'b1;
        @(negedge clk); if1.in_valid = 1'b1; if1.in_data = 8'h99;
        @(negedge clk); if1.in_valid = 1'b0;
        push_frame(8'h99, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs1();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL pre_reset idx%0d got %h want %h", idx, o, e); end
            if (idx == 3) begin
                #2 rst = 1'b1;
                #1 o = obs1();
                n_cmp++;
                if (o !== r) begin n_err++; $display("FAIL async_reset got %h want %h", o, r); end
                exp_q.delete();
            end
            idx++;
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk); if1.in_valid = 1'b1; if1.in_data = 8'h3C;
        @(negedge clk); if1.in_valid = 1'b0;
        push_frame(8'h3C, 1);
        idx = 1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs1();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL post_reset_3c T+%0d got %h want %h", idx, o, e); end
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_valid();
        obs_t e, o;
        int   cyc = 1;
        @(negedge clk); if3.in_valid = 1'b1; if3.in_data = 8'h5A;
        @(negedge clk);
        push_frame(8'h5A, 3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs3();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL ignore_valid T+%0d got %h want %h", cyc, o, e); end
            if (exp_q.size() != 0) begin
                if3.in_valid = 1'($urandom_range(0, 1));
                if3.in_data  = 8'($urandom);
            end else begin
                if3.in_valid = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        abort1 = 1'b0; abort3 = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = '0;
        if3.in_valid = 1'b0; if3.in_data = '0;
        test_reset();
        test_single_div1();
        test_div3();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_ignore_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
